// File: rtl/uart_rx_deserializer_if.sv
// Parallel-side signal bundle of the 8N1 receiver: synchronized RX line in,
// received byte plus status flags out, read strobe from the register block.
interface uart_rx_deserializer_if;
  logic       rx_sync_i;
  logic       rx_fall_i;
  logic       rd_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       avail_o;
  logic       overrun_o;
  logic       frame_err_o;
  logic       busy_o;

  modport slave (
    input  rx_sync_i, rx_fall_i, rd_i,
    output data_o, valid_o, avail_o, overrun_o, frame_err_o, busy_o
  );

  modport master (
    output rx_sync_i, rx_fall_i, rd_i,
    input  data_o, valid_o, avail_o, overrun_o, frame_err_o, busy_o
  );
endinterface

// File: rtl/uart_rx_deserializer.sv
// 8N1 serial receiver: mid-bit sampling off a bit-period counter, LSB-first
// shift, holding register with avail/overrun flags and framing-error pulse.
module uart_rx_deserializer #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                   sysClk_i,
  input  logic                   reset_ni,
  uart_rx_deserializer_if.slave  bus
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int H  = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] LAST_BIT  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] LAST_HALF = CW'(H - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]    r_idx, w_idx_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic          w_good, w_ferr;

  logic [7:0]    r_data;
  logic          r_valid, r_avail, r_ovr, r_ferr;

  // Counter reads k-1 during the k-th cycle after a clear, so the compare
  // values are one less than the sample distance.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CW'(1);
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_good      = 1'b0;
    w_ferr      = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (bus.rx_fall_i) w_state_nxt = START;
      end
      START: begin
        if (r_cnt == LAST_HALF) begin
          w_cnt_nxt = '0;
          if (bus.rx_sync_i) begin
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = DATA;
            w_idx_nxt   = 3'd0;
          end
        end
      end
      DATA: begin
        if (r_cnt == LAST_BIT) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {bus.rx_sync_i, r_shift[7:1]};
          w_idx_nxt   = r_idx + 3'd1;
          if (r_idx == 3'd7) w_state_nxt = STOP;
        end
      end
      STOP: begin
        if (r_cnt == LAST_BIT) begin
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
          if (bus.rx_sync_i) w_good = 1'b1;
          else               w_ferr = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sysClk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= 3'd0;
      r_shift <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  // A read coinciding with a completion consumes the old byte, so the new
  // one is held without flagging overrun.
  always_ff @(posedge sysClk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_data  <= 8'h00;
      r_valid <= 1'b0;
      r_avail <= 1'b0;
      r_ovr   <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_valid <= w_good;
      r_ferr  <= w_ferr;
      if (w_good) begin
        r_data  <= r_shift;
        r_avail <= 1'b1;
        r_ovr   <= bus.rd_i ? 1'b0 : (r_ovr | r_avail);
      end else if (bus.rd_i) begin
        r_avail <= 1'b0;
        r_ovr   <= 1'b0;
      end
    end
  end

  assign bus.data_o      = r_data;
  assign bus.valid_o     = r_valid;
  assign bus.avail_o     = r_avail;
  assign bus.overrun_o   = r_ovr;
  assign bus.frame_err_o = r_ferr;
  assign bus.busy_o      = (r_state != IDLE);
endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer at CLKS_PER_BIT=8: table of frames
// run back-to-back, plus read, glitch-start and mid-frame reset sequences.
module tb_uart_rx_deserializer;
  localparam int N = 8;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  uart_rx_deserializer_if bus();

  uart_rx_deserializer #(.CLKS_PER_BIT(N)) dut (
    .sysClk_i (clk),
    .reset_ni (rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    bit         stopb;
    int         rd_off;
    bit         good;
    logic [7:0] edata;
    bit         eavail;
    bit         eovr;
  } vec_t;

  typedef struct {
    int         vcnt;
    int         fcnt;
    int         vofs;
    int         fofs;
    logic       busy1;
    logic       busy77;
    logic [7:0] data77;
    logic       avail77;
    logic       ovr77;
  } res_t;

  vec_t vt[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Line level at offset o from the start-bit edge.
  function automatic logic lvl(input logic [7:0] d, input bit stopb, input int o);
    if (o < N)           return 1'b0;
    else if (o < 9 * N)  return d[o / N - 1];
    else if (o < 10 * N) return stopb;
    else                 return 1'b1;
  endfunction

  // Drives one frame: start edge at offset 0, observes offsets 1..79; the
  // next call places its start edge at offset 80, right after the stop bit.
  task automatic frame(input logic [7:0] d, input bit stopb, input int rd_off,
                       output res_t r);
    r.vcnt = 0; r.fcnt = 0; r.vofs = -1; r.fofs = -1;
    r.busy1 = 1'b0; r.busy77 = 1'b0; r.data77 = 8'h00;
    r.avail77 = 1'b0; r.ovr77 = 1'b0;
    @(negedge clk);
    bus.rx_fall_i = 1'b1;
    bus.rx_sync_i = 1'b0;
    bus.rd_i      = (rd_off == 0);
    for (int o = 1; o <= 79; o++) begin
      @(negedge clk);
      if (bus.valid_o === 1'b1) begin
        r.vcnt++;
        if (r.vofs < 0) r.vofs = o;
      end
      if (bus.frame_err_o === 1'b1) begin
        r.fcnt++;
        if (r.fofs < 0) r.fofs = o;
      end
      if (o == 1) r.busy1 = bus.busy_o;
      if (o == 77) begin
        r.busy77  = bus.busy_o;
        r.data77  = bus.data_o;
        r.avail77 = bus.avail_o;
        r.ovr77   = bus.overrun_o;
      end
      bus.rx_fall_i = 1'b0;
      bus.rx_sync_i = lvl(d, stopb, o);
      bus.rd_i      = (o == rd_off);
    end
  endtask

  initial begin
    res_t r;
    int   cv, cf, cb;

    vt[0] = '{8'hA5, 1'b1, -1, 1'b1, 8'hA5, 1'b1, 1'b0};
    vt[1] = '{8'h3C, 1'b0, -1, 1'b0, 8'hA5, 1'b1, 1'b0};
    vt[2] = '{8'h11, 1'b1, 10, 1'b1, 8'h11, 1'b1, 1'b0};
    vt[3] = '{8'h22, 1'b1, -1, 1'b1, 8'h22, 1'b1, 1'b1};
    vt[4] = '{8'h00, 1'b1, -1, 1'b1, 8'h00, 1'b1, 1'b0};
    vt[5] = '{8'hFF, 1'b1, -1, 1'b1, 8'hFF, 1'b1, 1'b1};
    vt[6] = '{8'h5A, 1'b1, 76, 1'b1, 8'h5A, 1'b1, 1'b0};

    rst_n = 1'b0;
    bus.rx_sync_i = 1'b1;
    bus.rx_fall_i = 1'b0;
    bus.rd_i      = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst data",  32'(bus.data_o), 32'h00);
    chk("rst valid", 32'(bus.valid_o), 0);
    chk("rst avail", 32'(bus.avail_o), 0);
    chk("rst ovr",   32'(bus.overrun_o), 0);
    chk("rst ferr",  32'(bus.frame_err_o), 0);
    chk("rst busy",  32'(bus.busy_o), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      if (i == 4) begin
        // Stand-alone read: clears avail and overrun, byte stays.
        @(negedge clk);
        bus.rd_i = 1'b1;
        @(negedge clk);
        bus.rd_i = 1'b0;
        chk("rd avail", 32'(bus.avail_o), 0);
        chk("rd ovr",   32'(bus.overrun_o), 0);
        chk("rd data",  32'(bus.data_o), 32'h22);
        // Read with nothing held changes nothing.
        bus.rd_i = 1'b1;
        @(negedge clk);
        bus.rd_i = 1'b0;
        chk("rd idle avail", 32'(bus.avail_o), 0);
      end
      frame(vt[i].d, vt[i].stopb, vt[i].rd_off, r);
      chk($sformatf("v%0d vcnt", i), 32'(r.vcnt), vt[i].good ? 1 : 0);
      chk($sformatf("v%0d fcnt", i), 32'(r.fcnt), vt[i].good ? 0 : 1);
      chk($sformatf("v%0d pulse ofs", i), 32'(vt[i].good ? r.vofs : r.fofs), 77);
      chk($sformatf("v%0d busy1", i), 32'(r.busy1), 1);
      chk($sformatf("v%0d busy77", i), 32'(r.busy77), 0);
      chk($sformatf("v%0d data", i), 32'(r.data77), 32'(vt[i].edata));
      chk($sformatf("v%0d avail", i), 32'(r.avail77), 32'(vt[i].eavail));
      chk($sformatf("v%0d ovr", i), 32'(r.ovr77), 32'(vt[i].eovr));
    end

    // Glitch start: line back high before the mid-start sample.
    cv = 0; cf = 0;
    @(negedge clk);
    bus.rx_fall_i = 1'b1;
    bus.rx_sync_i = 1'b0;
    for (int o = 1; o <= 10; o++) begin
      @(negedge clk);
      if (bus.valid_o === 1'b1) cv++;
      if (bus.frame_err_o === 1'b1) cf++;
      if (o == 4) chk("glitch busy4", 32'(bus.busy_o), 1);
      if (o == 5) chk("glitch busy5", 32'(bus.busy_o), 0);
      bus.rx_fall_i = 1'b0;
      bus.rx_sync_i = (o >= 2);
    end
    chk("glitch valid", 32'(cv), 0);
    chk("glitch ferr",  32'(cf), 0);
    chk("glitch data",  32'(bus.data_o), 32'h5A);

    // Reset in the middle of a frame.
    @(negedge clk);
    bus.rx_fall_i = 1'b1;
    bus.rx_sync_i = 1'b0;
    for (int o = 1; o <= 29; o++) begin
      @(negedge clk);
      bus.rx_fall_i = 1'b0;
      bus.rx_sync_i = lvl(8'h00, 1'b1, o);
    end
    @(negedge clk);
    chk("mid busy", 32'(bus.busy_o), 1);
    rst_n = 1'b0;
    #1;
    chk("arst data",  32'(bus.data_o), 32'h00);
    chk("arst valid", 32'(bus.valid_o), 0);
    chk("arst avail", 32'(bus.avail_o), 0);
    chk("arst ovr",   32'(bus.overrun_o), 0);
    chk("arst ferr",  32'(bus.frame_err_o), 0);
    chk("arst busy",  32'(bus.busy_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.rx_sync_i = 1'b0;
    cv = 0; cf = 0; cb = 0;
    for (int o = 0; o < 100; o++) begin
      @(negedge clk);
      if (bus.valid_o === 1'b1) cv++;
      if (bus.frame_err_o === 1'b1) cf++;
      if (bus.busy_o === 1'b1) cb++;
      bus.rx_sync_i = (o >= 40);
    end
    chk("post rst valid", 32'(cv), 0);
    chk("post rst ferr",  32'(cf), 0);
    chk("post rst busy",  32'(cb), 0);

    frame(8'h96, 1'b1, -1, r);
    chk("after vcnt", 32'(r.vcnt), 1);
    chk("after ofs",  32'(r.vofs), 77);
    chk("after data", 32'(r.data77), 32'h96);
    chk("after avail", 32'(r.avail77), 1);
    chk("after ovr",  32'(r.ovr77), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
